rdm_llr_packer: RTL

Upstream feeder of the rate-dematching FSM. Accepts a serial stream of 6-bit soft LLRs for one code block (E LLRs), packs them 16 per 96-bit word, and writes the words into the input buffer from a programmable base address, so that the RDM stage can later read them by offset address. One job per start pulse. A trailing partial word is zero-padded. A done pulse tells the control path that the buffer is ready for `i_RDM_Data_Request` to be raised downstream.

---
 rtl/rdm_llr_packer_if.sv | 31 +++
 rtl/rdm_llr_packer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/rdm_llr_packer_if.sv
// Handshake and buffer-write bundle between the LLR feeder, rdm_llr_packer and the input buffer.
// The slave modport is the packer's view; the master modport is the feeder/control view.
interface rdm_llr_packer_if #(
   parameter int LLR_W  = 6,
   parameter int LANES  = 16,
   parameter int ADDR_W = 16,
   parameter int E_W    = 14
);
   logic                     i_start;
   logic [E_W-1:0]           i_E_Size;
   logic [ADDR_W-1:0]        i_Base_Address;
   logic                     i_llr_valid;
   logic [LLR_W-1:0]         i_llr_data;
   logic                     o_llr_ready;
   logic                     o_wr_en;
   logic [ADDR_W-1:0]        o_wr_addr;
   logic [LLR_W*LANES-1:0]   o_wr_data;
   logic                     o_busy;
   logic                     o_done;
   logic [ADDR_W-1:0]        o_word_count;

   modport master (
      output i_start, i_E_Size, i_Base_Address, i_llr_valid, i_llr_data,
      input  o_llr_ready, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_word_count
   );

   modport slave (
      input  i_start, i_E_Size, i_Base_Address, i_llr_valid, i_llr_data,
      output o_llr_ready, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_word_count
   );
endinterface

// File: rtl/rdm_llr_packer.sv
// Packs a serial stream of soft LLRs into LANES-wide words and writes them to the
// rate-dematching input buffer starting at a programmable base address, one job per start.
module rdm_llr_packer #(
   parameter int LLR_W  = 6,
   parameter int LANES  = 16,
   parameter int ADDR_W = 16,
   parameter int E_W    = 14
) (
   input  logic              i_core_clk,
   input  logic              i_rx_rst,
   rdm_llr_packer_if.slave   pk
);
   localparam int WORD_W = LLR_W * LANES;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PACK = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               state_r;
   state_t               state_s;
   logic [E_W-1:0]       e_r;
   logic [E_W-1:0]       llr_cnt_r;
   logic [ADDR_W-1:0]    base_r;
   logic [ADDR_W-1:0]    word_cnt_r;
   logic [LANE_W-1:0]    lane_cnt_r;
   logic [WORD_W-1:0]    stage_r;
   logic [WORD_W-1:0]    stage_s;
   logic                 wr_en_r;
   logic [ADDR_W-1:0]    wr_addr_r;
   logic [WORD_W-1:0]    wr_data_r;
   logic                 busy_r;
   logic                 done_r;
   logic                 start_ok_s;
   logic                 accept_s;
   logic                 last_s;
   logic                 emit_s;

   // FSM state register
   always_ff @(posedge i_core_clk) begin
      if (i_rx_rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state, beat acceptance and staging-word merge of the incoming LLR
   always_comb begin
      state_s    = state_r;
      start_ok_s = 1'b0;
      accept_s   = 1'b0;
      last_s     = 1'b0;
      emit_s     = 1'b0;
      stage_s    = stage_r;
      case (state_r)
         ST_IDLE: begin
            if (pk.i_start) begin
               start_ok_s = 1'b1;
               state_s    = (pk.i_E_Size != {E_W{1'b0}}) ? ST_PACK : ST_DONE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_PACK: begin
            if (pk.i_llr_valid) begin
               accept_s = 1'b1;
               stage_s[lane_cnt_r*LLR_W +: LLR_W] = pk.i_llr_data;
               last_s   = ((llr_cnt_r + E_W'(1)) == e_r);
               emit_s   = last_s | (lane_cnt_r == LANE_LAST);
               state_s  = last_s ? ST_DONE : ST_PACK;
            end else begin
               state_s = ST_PACK;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Job registers, counters, staging word and registered buffer-write port.
   // Staging is cleared on every emit, so lanes past the last beat are already zero.
   always_ff @(posedge i_core_clk) begin
      if (i_rx_rst) begin
         e_r        <= {E_W{1'b0}};
         base_r     <= {ADDR_W{1'b0}};
         llr_cnt_r  <= {E_W{1'b0}};
         word_cnt_r <= {ADDR_W{1'b0}};
         lane_cnt_r <= {LANE_W{1'b0}};
         stage_r    <= {WORD_W{1'b0}};
         wr_en_r    <= 1'b0;
         wr_addr_r  <= {ADDR_W{1'b0}};
         wr_data_r  <= {WORD_W{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         wr_en_r <= emit_s;
         busy_r  <= (state_s != ST_IDLE);
         done_r  <= (state_s == ST_DONE);
         if (start_ok_s) begin
            e_r        <= pk.i_E_Size;
            base_r     <= pk.i_Base_Address;
            llr_cnt_r  <= {E_W{1'b0}};
            word_cnt_r <= {ADDR_W{1'b0}};
            lane_cnt_r <= {LANE_W{1'b0}};
            stage_r    <= {WORD_W{1'b0}};
         end else if (accept_s) begin
            llr_cnt_r  <= llr_cnt_r + E_W'(1);
            lane_cnt_r <= (lane_cnt_r == LANE_LAST) ? {LANE_W{1'b0}} : (lane_cnt_r + LANE_W'(1));
            if (emit_s) begin
               stage_r    <= {WORD_W{1'b0}};
               wr_addr_r  <= base_r + word_cnt_r;
               wr_data_r  <= stage_s;
               word_cnt_r <= word_cnt_r + ADDR_W'(1);
            end else begin
               stage_r <= stage_s;
            end
         end
      end
   end

   assign pk.o_llr_ready  = (state_r == ST_PACK);
   assign pk.o_wr_en      = wr_en_r;
   assign pk.o_wr_addr    = wr_addr_r;
   assign pk.o_wr_data    = wr_data_r;
   assign pk.o_busy       = busy_r;
   assign pk.o_done       = done_r;
   assign pk.o_word_count = word_cnt_r;
endmodule
